// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus field positions and the trap/return sequencer states.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_W_MEPC,
      ST_W_MCAUSE,
      ST_W_MTVAL,
      ST_W_MSTATUS,
      ST_R_MTVEC,
      ST_R_MEPC,
      ST_W_MSTATUS_RET,
      ST_DONE
   } trap_state_e;

endpackage

// File: rtl/csr_port_arb.sv
// Combinational owner select for the single CSR port: a Zicsr access wins only in an
// idle cycle with no trap/mret request, otherwise the sequencer drives the port.
module csr_port_arb #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CSR_AW = 12
) (
   input  logic              idle_i,
   input  logic              trap_req_i,
   input  logic              mret_req_i,
   input  logic              inst_valid_i,
   input  logic              inst_we_i,
   input  logic [CSR_AW-1:0] inst_addr_i,
   input  logic [XLEN-1:0]   inst_wdata_i,
   input  logic              fsm_we_i,
   input  logic [CSR_AW-1:0] fsm_addr_i,
   input  logic [XLEN-1:0]   fsm_wdata_i,
   output logic              grant_o,
   output logic              csr_we_o,
   output logic [CSR_AW-1:0] csr_addr_o,
   output logic [XLEN-1:0]   csr_wdata_o
);

   always_comb begin
      grant_o     = idle_i & ~trap_req_i & ~mret_req_i & inst_valid_i;
      csr_we_o    = grant_o ? inst_we_i    : fsm_we_i;
      csr_addr_o  = grant_o ? inst_addr_i  : fsm_addr_i;
      csr_wdata_o = grant_o ? inst_wdata_i : fsm_wdata_i;
   end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap/return sequencer for ecall and mret, sharing the CSR port with Zicsr accesses.
// Define CSR_TRAP_MTVAL_EN to add the mtval write state to the trap path.
module csr_trap_ctrl
   import csr_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CSR_AW = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              trap_req,
   input  logic [XLEN-1:0]   trap_pc,
   input  logic [XLEN-1:0]   trap_cause,
   input  logic [XLEN-1:0]   trap_tval,
   input  logic              mret_req,
   input  logic              inst_csr_valid,
   input  logic              inst_csr_we,
   input  logic [CSR_AW-1:0] inst_csr_addr,
   input  logic [XLEN-1:0]   inst_csr_wdata,
   output logic              inst_csr_grant,
   output logic              csr_we,
   output logic [CSR_AW-1:0] csr_addr,
   output logic [XLEN-1:0]   csr_wdata,
   input  logic [XLEN-1:0]   csr_rdata,
   output logic              busy,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc
);

   trap_state_e       state_q, state_d;
   logic [XLEN-1:0]   pc_q, cause_q, target_q;
   logic              busy_q, redir_q;
   logic              fsm_we;
   logic [CSR_AW-1:0] fsm_addr;
   logic [XLEN-1:0]   fsm_wdata;

`ifdef CSR_TRAP_MTVAL_EN
   logic [XLEN-1:0]   tval_q;
`else
   logic              unused_tval;
   assign unused_tval = ^trap_tval;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (trap_req)      state_d = ST_W_MEPC;
            else if (mret_req) state_d = ST_R_MEPC;
         end
         ST_W_MEPC:        state_d = ST_W_MCAUSE;
`ifdef CSR_TRAP_MTVAL_EN
         ST_W_MCAUSE:      state_d = ST_W_MTVAL;
`else
         ST_W_MCAUSE:      state_d = ST_W_MSTATUS;
`endif
         ST_W_MTVAL:       state_d = ST_W_MSTATUS;
         ST_W_MSTATUS:     state_d = ST_R_MTVEC;
         ST_R_MTVEC:       state_d = ST_DONE;
         ST_R_MEPC:        state_d = ST_W_MSTATUS_RET;
         ST_W_MSTATUS_RET: state_d = ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // mstatus updates are read-modify-write within one cycle using the combinational read.
   always_comb begin
      fsm_we    = 1'b0;
      fsm_addr  = '0;
      fsm_wdata = '0;
      case (state_q)
         ST_W_MEPC: begin
            fsm_we    = 1'b1;
            fsm_addr  = CSR_AW'(CSR_MEPC);
            fsm_wdata = {pc_q[XLEN-1:2], 2'b00};
         end
         ST_W_MCAUSE: begin
            fsm_we    = 1'b1;
            fsm_addr  = CSR_AW'(CSR_MCAUSE);
            fsm_wdata = cause_q;
         end
`ifdef CSR_TRAP_MTVAL_EN
         ST_W_MTVAL: begin
            fsm_we    = 1'b1;
            fsm_addr  = CSR_AW'(CSR_MTVAL);
            fsm_wdata = tval_q;
         end
`endif
         ST_W_MSTATUS: begin
            fsm_we                                   = 1'b1;
            fsm_addr                                 = CSR_AW'(CSR_MSTATUS);
            fsm_wdata                                = csr_rdata;
            fsm_wdata[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
            fsm_wdata[MSTATUS_MIE]                   = 1'b0;
            fsm_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
         end
         ST_R_MTVEC: fsm_addr = CSR_AW'(CSR_MTVEC);
         ST_R_MEPC:  fsm_addr = CSR_AW'(CSR_MEPC);
         ST_W_MSTATUS_RET: begin
            fsm_we                                   = 1'b1;
            fsm_addr                                 = CSR_AW'(CSR_MSTATUS);
            fsm_wdata                                = csr_rdata;
            fsm_wdata[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
            fsm_wdata[MSTATUS_MPIE]                  = 1'b1;
            fsm_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         cause_q  <= '0;
         target_q <= '0;
         busy_q   <= 1'b0;
         redir_q  <= 1'b0;
`ifdef CSR_TRAP_MTVAL_EN
         tval_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
         redir_q <= (state_d == ST_DONE);
         if (state_q == ST_IDLE && trap_req) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
`ifdef CSR_TRAP_MTVAL_EN
            tval_q  <= trap_tval;
`endif
         end
         if (state_q == ST_R_MTVEC) target_q <= {csr_rdata[XLEN-1:2], 2'b00};
         if (state_q == ST_R_MEPC)  target_q <= csr_rdata;
      end
   end

   assign busy           = busy_q;
   assign redirect_valid = redir_q;
   assign redirect_pc    = redir_q ? target_q : '0;

   csr_port_arb #(
      .XLEN   (XLEN),
      .CSR_AW (CSR_AW)
   ) u_arb (
      .idle_i       (state_q == ST_IDLE),
      .trap_req_i   (trap_req),
      .mret_req_i   (mret_req),
      .inst_valid_i (inst_csr_valid),
      .inst_we_i    (inst_csr_we),
      .inst_addr_i  (inst_csr_addr),
      .inst_wdata_i (inst_csr_wdata),
      .fsm_we_i     (fsm_we),
      .fsm_addr_i   (fsm_addr),
      .fsm_wdata_i  (fsm_wdata),
      .grant_o      (inst_csr_grant),
      .csr_we_o     (csr_we),
      .csr_addr_o   (csr_addr),
      .csr_wdata_o  (csr_wdata)
   );

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: a behavioural CSR file plus per-transaction expectations
// derived from the trap/mret rules (define CSR_TRAP_MTVAL_EN to match that build).
module tb_csr_trap_ctrl;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 12;
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
`ifdef CSR_TRAP_MTVAL_EN
   localparam int TRAP_LAT = 6;
   localparam bit MTVAL_ON = 1'b1;
`else
   localparam int TRAP_LAT = 5;
   localparam bit MTVAL_ON = 1'b0;
`endif
   localparam int MRET_LAT = 3;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            trap_req = 1'b0, mret_req = 1'b0;
   logic [XLEN-1:0] trap_pc = '0, trap_cause = '0, trap_tval = '0;
   logic            inst_csr_valid = 1'b0, inst_csr_we = 1'b0;
   logic [AW-1:0]   inst_csr_addr = '0;
   logic [XLEN-1:0] inst_csr_wdata = '0;
   logic            inst_csr_grant, csr_we, busy, redirect_valid;
   logic [AW-1:0]   csr_addr;
   logic [XLEN-1:0] csr_wdata, csr_rdata, redirect_pc;

   logic [31:0]     csrf [0:4095];
   logic            mem_clr = 1'b0, bd_we = 1'b0;
   logic [11:0]     bd_addr = '0;
   logic [31:0]     bd_data = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   csr_trap_ctrl #(.XLEN(XLEN), .CSR_AW(AW)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .trap_req       (trap_req),
      .trap_pc        (trap_pc),
      .trap_cause     (trap_cause),
      .trap_tval      (trap_tval),
      .mret_req       (mret_req),
      .inst_csr_valid (inst_csr_valid),
      .inst_csr_we    (inst_csr_we),
      .inst_csr_addr  (inst_csr_addr),
      .inst_csr_wdata (inst_csr_wdata),
      .inst_csr_grant (inst_csr_grant),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .busy           (busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // Behavioural CSR file: combinational read, write on the clock edge.
   assign csr_rdata = csrf[csr_addr];
   always @(posedge clk) begin
      if (mem_clr) for (int i = 0; i < 4096; i++) csrf[i] <= '0;
      else if (bd_we)  csrf[bd_addr] <= bd_data;
      else if (csr_we) csrf[csr_addr] <= csr_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      tick();
      bd_we   = 1'b0;
   endtask

   function automatic logic [31:0] ms_after_trap(input logic [31:0] m);
      logic [31:0] r;
      r = m & ~32'h0000_1888;
      return r | (m[3] ? 32'h80 : 32'h0) | 32'h1800;
   endfunction

   function automatic logic [31:0] ms_after_mret(input logic [31:0] m);
      logic [31:0] r;
      r = m & ~32'h0000_1888;
      return r | (m[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
   endfunction

   // One trap or mret sequence, called in an IDLE cycle at posedge+1.
   task automatic run_seq(input bit is_trap, input bit both, input bit with_inst,
                          input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
      logic [31:0] ms0, mepc0, mcause0, mtval0, mscr0, exp_tgt, idata;
      int lat;
      ms0     = csrf[A_MSTATUS];
      mepc0   = csrf[A_MEPC];
      mcause0 = csrf[A_MCAUSE];
      mtval0  = csrf[A_MTVAL];
      mscr0   = csrf[A_MSCRATCH];
      lat     = is_trap ? TRAP_LAT : MRET_LAT;
      exp_tgt = is_trap ? (csrf[A_MTVEC] & ~32'h3) : mepc0;
      idata   = $urandom;

      trap_req       = is_trap;
      mret_req       = is_trap ? both : 1'b1;
      trap_pc        = pc;
      trap_cause     = cause;
      trap_tval      = tval;
      inst_csr_valid = with_inst;
      inst_csr_we    = 1'b1;
      inst_csr_addr  = A_MSCRATCH;
      inst_csr_wdata = idata;
      #1;
      check("grant_at_req", {31'b0, inst_csr_grant}, 32'd0);
      check("busy_before", {31'b0, busy}, 32'd0);
      tick();
      for (int c = 1; c <= lat + 1; c++) begin
         if (c < lat) begin
            trap_req   = 1'($urandom_range(0, 1));
            mret_req   = 1'($urandom_range(0, 1));
            trap_pc    = $urandom;
            trap_cause = $urandom;
            trap_tval  = $urandom;
         end else begin
            trap_req = 1'b0;
            mret_req = 1'b0;
         end
         #1;
         check("busy", {31'b0, busy}, {31'b0, c <= lat});
         check("redirect_valid", {31'b0, redirect_valid}, {31'b0, c == lat});
         if (c == lat) check("redirect_pc", redirect_pc, exp_tgt);
         if (c == lat) check("no_inst_write_busy", csrf[A_MSCRATCH], mscr0);
         if (with_inst) check("grant", {31'b0, inst_csr_grant}, {31'b0, c == lat + 1});
         if (c == 1) begin
            check("first_we", {31'b0, csr_we}, {31'b0, is_trap});
            check("first_addr", {20'b0, csr_addr}, {20'b0, A_MEPC});
         end
         if (c <= lat) tick();
      end
      if (with_inst) begin
         tick();
         inst_csr_valid = 1'b0;
      end
      check("mscratch", csrf[A_MSCRATCH], with_inst ? idata : mscr0);
      check("mstatus", csrf[A_MSTATUS], is_trap ? ms_after_trap(ms0) : ms_after_mret(ms0));
      check("mepc", csrf[A_MEPC], is_trap ? (pc & ~32'h3) : mepc0);
      check("mcause", csrf[A_MCAUSE], is_trap ? cause : mcause0);
      check("mtval", csrf[A_MTVAL], (is_trap && MTVAL_ON) ? tval : mtval0);
   endtask

   initial begin
      mem_clr = 1'b1;
      tick();
      tick();
      mem_clr = 1'b0;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_csr_we", {31'b0, csr_we}, 32'd0);
      check("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
      check("rst_csr_wdata", csr_wdata, 32'd0);
      check("rst_grant", {31'b0, inst_csr_grant}, 32'd0);
      #2 rstn = 1'b1;
      tick();

      // Zicsr write and read own the port in IDLE.
      inst_csr_valid = 1'b1;
      inst_csr_we    = 1'b1;
      inst_csr_addr  = A_MTVEC;
      inst_csr_wdata = 32'h1234;
      #1;
      check("arb_grant", {31'b0, inst_csr_grant}, 32'd1);
      check("arb_we", {31'b0, csr_we}, 32'd1);
      check("arb_addr", {20'b0, csr_addr}, {20'b0, A_MTVEC});
      check("arb_wdata", csr_wdata, 32'h1234);
      tick();
      inst_csr_we   = 1'b0;
      inst_csr_addr = A_MSTATUS;
      #1;
      check("arb_mtvec_written", csrf[A_MTVEC], 32'h1234);
      check("arb_read_we", {31'b0, csr_we}, 32'd0);
      check("arb_read_grant", {31'b0, inst_csr_grant}, 32'd1);
      inst_csr_valid = 1'b0;
      tick();

      // Directed trap then mret back-to-back.
      bd_write(A_MTVEC, 32'h8000_0100);
      bd_write(A_MSTATUS, 32'h0000_0008);
      run_seq(1'b1, 1'b0, 1'b0, 32'h8000_0044, 32'd11, 32'hDEAD_BEEF);
      check("trap_mstatus_val", csrf[A_MSTATUS], 32'h0000_1880);
      bd_write(A_MEPC, 32'h8000_0048);
      run_seq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      check("mret_mstatus_val", csrf[A_MSTATUS], 32'h0000_1888);

      // Everything requested at once: trap wins, Zicsr waits for IDLE.
      run_seq(1'b1, 1'b1, 1'b1, 32'h8000_0207, 32'd11, 32'h0BAD_F00D);
      run_seq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 2) == 0) bd_write(A_MTVEC, $urandom);
         if ($urandom_range(0, 2) == 0) bd_write(A_MSTATUS, $urandom);
         if ($urandom_range(0, 2) == 0) bd_write(A_MEPC, $urandom);
         run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom);
      end

      // Reset during W_MCAUSE: outputs clear at once, mepc write stays, no redirect.
      bd_write(A_MEPC, 32'h1111_0000);
      bd_write(A_MCAUSE, 32'd5);
      trap_req   = 1'b1;
      trap_pc    = 32'h8000_0200;
      trap_cause = 32'd11;
      tick();
      trap_req = 1'b0;
      tick();
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_csr_we", {31'b0, csr_we}, 32'd0);
      check("mid_rst_csr_addr", {20'b0, csr_addr}, 32'd0);
      check("mid_rst_csr_wdata", csr_wdata, 32'd0);
      check("mid_rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
      check("mid_rst_redirect_pc", redirect_pc, 32'd0);
      check("mid_rst_mepc", csrf[A_MEPC], 32'h8000_0200);
      check("mid_rst_mcause", csrf[A_MCAUSE], 32'd5);
      tick();
      #3 rstn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         check("post_rst_redirect", {31'b0, redirect_valid}, 32'd0);
         check("post_rst_busy", {31'b0, busy}, 32'd0);
      end
      check("post_rst_mcause", csrf[A_MCAUSE], 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
